// File: rtl/sram_macro_ctrl.sv
// rtl/sram_macro_ctrl.sv - valid/ready front end for a single-port SRAM macro
// Drives active-low macro pins and buffers 1-cycle-latency read data in a credit-checked FIFO.
module sram_macro_ctrl #(
  parameter int         WIDTH      = 64,
  parameter int         ADDR_WIDTH = 9,
  parameter int         DEPTH      = 2,
  parameter logic [1:0] RTSEL_VAL  = 2'b01,
  parameter logic [1:0] WTSEL_VAL  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [WIDTH/8-1:0]    req_wmask,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [WIDTH-1:0]      sram_d,
  output logic [WIDTH-1:0]      sram_bweb,
  input  logic [WIDTH-1:0]      sram_q,
  output logic [1:0]            sram_rtsel,
  output logic [1:0]            sram_wtsel
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = CW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_inflight;

  logic          w_pop;
  logic          w_push;
  logic          w_acc;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [OW-1:0] w_occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_valid = (r_count != '0);
  assign rd_data  = r_mem[r_rptr];
  assign w_pop    = rd_valid && rd_ready;
  assign w_push   = r_inflight;

  // Credits: a read may issue only if the slot it will land in is guaranteed free,
  // counting the entry leaving this cycle.
  assign w_occ     = {1'b0, r_count} + OW'(r_inflight) - OW'(w_pop);
  assign req_ready = req_write || (w_occ < OW'(DEPTH));

  assign w_acc    = req_valid && req_ready;
  assign w_rd_acc = w_acc && !req_write;
  assign w_wr_acc = w_acc && req_write && rst_n;

  assign sram_ceb   = ~(w_acc && rst_n);
  assign sram_web   = ~w_wr_acc;
  assign sram_a     = req_addr;
  assign sram_d     = req_wdata;
  assign sram_rtsel = RTSEL_VAL;
  assign sram_wtsel = WTSEL_VAL;

  for (genvar b = 0; b < WIDTH / 8; b++) begin : g_bweb
    assign sram_bweb[8*b +: 8] = {8{~(w_wr_acc && req_wmask[b])}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_inflight <= w_rd_acc;
      if (w_push) begin
        r_mem[r_wptr] <= sram_q;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
